// File: rtl/fft4_stream.sv
// Streaming 4-point complex DFT: collects a four-sample frame, computes every bin in
// a single cycle, then emits the bins one per handshake with backpressure.
module fft4_stream #(
    parameter int W  = 4,
    parameter int OW = W + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_re,
    input  logic [W-1:0]  in_im,
    input  logic          in_inv,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_re,
    output logic [OW-1:0] out_im,
    output logic [1:0]    out_idx,
    output logic          out_last
);
    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    state_t               state_r;
    logic [1:0]           n_r;
    logic [1:0]           k_r;
    logic                 mode_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic                 out_last_r;
    logic [1:0]           out_idx_r;
    logic signed [OW-1:0] out_re_r;
    logic signed [OW-1:0] out_im_r;
    logic [W-1:0]         x_re_r [4];
    logic [W-1:0]         x_im_r [4];
    logic signed [OW-1:0] bin_re_r [4];
    logic signed [OW-1:0] bin_im_r [4];

    logic signed [OW-1:0] xr_s [4];
    logic signed [OW-1:0] xi_s [4];
    logic signed [OW-1:0] bin_re_s [4];
    logic signed [OW-1:0] bin_im_s [4];
    logic signed [OW-1:0] sac_re_s, sac_im_s, sbd_re_s, sbd_im_s;
    logic signed [OW-1:0] p_re_s, p_im_s, q_re_s, q_im_s;
    logic signed [OW-1:0] f1_re_s, f1_im_s, f3_re_s, f3_im_s;
    logic                 in_fire_s;
    logic                 out_fire_s;

    function automatic logic signed [OW-1:0] sext(input logic [W-1:0] v);
        return {{(OW - W){v[W-1]}}, v};
    endfunction

    assign in_fire_s  = in_valid & in_ready_r;
    assign out_fire_s = out_valid_r & out_ready;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_re    = out_re_r;
    assign out_im    = out_im_r;
    assign out_idx   = out_idx_r;
    assign out_last  = out_last_r;

    // Radix-2 butterflies over the stored frame; inverse mode only swaps bins 1 and 3.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            xr_s[i] = sext(x_re_r[i]);
            xi_s[i] = sext(x_im_r[i]);
        end
        sac_re_s = xr_s[0] + xr_s[2];
        sac_im_s = xi_s[0] + xi_s[2];
        sbd_re_s = xr_s[1] + xr_s[3];
        sbd_im_s = xi_s[1] + xi_s[3];
        p_re_s   = xr_s[0] - xr_s[2];
        p_im_s   = xi_s[0] - xi_s[2];
        q_re_s   = xr_s[1] - xr_s[3];
        q_im_s   = xi_s[1] - xi_s[3];
        f1_re_s  = p_re_s + q_im_s;
        f1_im_s  = p_im_s - q_re_s;
        f3_re_s  = p_re_s - q_im_s;
        f3_im_s  = p_im_s + q_re_s;
        bin_re_s[0] = sac_re_s + sbd_re_s;
        bin_im_s[0] = sac_im_s + sbd_im_s;
        bin_re_s[2] = sac_re_s - sbd_re_s;
        bin_im_s[2] = sac_im_s - sbd_im_s;
        if (mode_r) begin
            bin_re_s[1] = f3_re_s;
            bin_im_s[1] = f3_im_s;
            bin_re_s[3] = f1_re_s;
            bin_im_s[3] = f1_im_s;
        end else begin
            bin_re_s[1] = f1_re_s;
            bin_im_s[1] = f1_im_s;
            bin_re_s[3] = f3_re_s;
            bin_im_s[3] = f3_im_s;
        end
    end

    // Frame FSM, sample/bin storage and registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_COLLECT;
            n_r         <= 2'd0;
            k_r         <= 2'd0;
            mode_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_re_r    <= {OW{1'b0}};
            out_im_r    <= {OW{1'b0}};
            out_idx_r   <= 2'd0;
            out_last_r  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                x_re_r[i]   <= {W{1'b0}};
                x_im_r[i]   <= {W{1'b0}};
                bin_re_r[i] <= {OW{1'b0}};
                bin_im_r[i] <= {OW{1'b0}};
            end
        end else begin
            case (state_r)
                ST_COLLECT: begin
                    if (in_fire_s) begin
                        x_re_r[n_r] <= in_re;
                        x_im_r[n_r] <= in_im;
                        if (n_r == 2'd0) begin
                            mode_r <= in_inv;
                        end
                        if (n_r == 2'd3) begin
                            state_r    <= ST_COMPUTE;
                            in_ready_r <= 1'b0;
                            n_r        <= 2'd0;
                        end else begin
                            n_r <= n_r + 2'd1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    for (int i = 0; i < 4; i++) begin
                        bin_re_r[i] <= bin_re_s[i];
                        bin_im_r[i] <= bin_im_s[i];
                    end
                    // Bin 0 goes straight to the output stage so it is valid next cycle.
                    out_re_r    <= bin_re_s[0];
                    out_im_r    <= bin_im_s[0];
                    out_idx_r   <= 2'd0;
                    out_last_r  <= 1'b0;
                    out_valid_r <= 1'b1;
                    k_r         <= 2'd0;
                    state_r     <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (out_fire_s) begin
                        if (k_r == 2'd3) begin
                            state_r     <= ST_COLLECT;
                            in_ready_r  <= 1'b1;
                            out_valid_r <= 1'b0;
                            out_re_r    <= {OW{1'b0}};
                            out_im_r    <= {OW{1'b0}};
                            out_idx_r   <= 2'd0;
                            out_last_r  <= 1'b0;
                            k_r         <= 2'd0;
                        end else begin
                            out_re_r   <= bin_re_r[k_r + 2'd1];
                            out_im_r   <= bin_im_r[k_r + 2'd1];
                            out_idx_r  <= k_r + 2'd1;
                            out_last_r <= (k_r == 2'd2);
                            k_r        <= k_r + 2'd1;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_COLLECT;
                    n_r         <= 2'd0;
                    k_r         <= 2'd0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fft4_stream.sv
// Bench for fft4_stream: directed vector table plus randomized frames at W = 4, 8, 12
// checked against a direct DFT-sum reference model.
module tb_fft4_stream;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_inv = 1'b0;
    logic        out_ready = 1'b1;
    logic [3:0]  re4 = 4'd0, im4 = 4'd0;
    logic [7:0]  re8 = 8'd0, im8 = 8'd0;
    logic [11:0] re12 = 12'd0, im12 = 12'd0;
    logic        rdy4, rdy8, rdy12, ov4, ov8, ov12, last4, last8, last12;
    logic [1:0]  idx4, idx8, idx12;
    logic [5:0]  q_re4, q_im4;
    logic [9:0]  q_re8, q_im8;
    logic [13:0] q_re12, q_im12;
    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          bin0_cyc = 0;

    typedef struct {
        int re[4];
        int im[4];
        int inv[4];
        int gap;
        int stall;
        int er[4];
        int ei[4];
    } vec_t;

    fft4_stream #(.W(4)) u_dut4 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
        .in_re(re4), .in_im(im4), .in_inv(in_inv), .out_valid(ov4), .out_ready(out_ready),
        .out_re(q_re4), .out_im(q_im4), .out_idx(idx4), .out_last(last4));
    fft4_stream #(.W(8)) u_dut8 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
        .in_re(re8), .in_im(im8), .in_inv(in_inv), .out_valid(ov8), .out_ready(out_ready),
        .out_re(q_re8), .out_im(q_im8), .out_idx(idx8), .out_last(last8));
    fft4_stream #(.W(12)) u_dut12 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy12),
        .in_re(re12), .in_im(im12), .in_inv(in_inv), .out_valid(ov12), .out_ready(out_ready),
        .out_re(q_re12), .out_im(q_im12), .out_idx(idx12), .out_last(last12));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic fail(input string nm);
        checks++;
        $display("FAIL %s: got no handshake, required one within the cycle bound", nm);
    endtask

    // DFT by direct summation: X[k] = sum x[n] * (-j)^(nk), or (+j)^(nk) when inverse.
    task automatic ref_dft(input int xr[4], input int xi[4], input int inv,
                           output int yr[4], output int yi[4]);
        for (int k = 0; k < 4; k++) begin
            yr[k] = 0;
            yi[k] = 0;
            for (int n = 0; n < 4; n++) begin
                int m;
                m = (n * k) % 4;
                if (inv != 0) m = (4 - m) % 4;
                case (m)
                    0: begin yr[k] += xr[n]; yi[k] += xi[n]; end
                    1: begin yr[k] += xi[n]; yi[k] -= xr[n]; end
                    2: begin yr[k] -= xr[n]; yi[k] -= xi[n]; end
                    default: begin yr[k] -= xi[n]; yi[k] += xr[n]; end
                endcase
            end
        end
    endtask

    task automatic put(input int r4, input int r8, input int r12,
                       input int i4, input int i8, input int i12, input int inv);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_inv = (inv != 0);
        re4 = r4[3:0];   im4 = i4[3:0];
        re8 = r8[7:0];   im8 = i8[7:0];
        re12 = r12[11:0]; im12 = i12[11:0];
        while (!(rdy4 && rdy8 && rdy12) && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (!rdy4) fail("put_timeout");
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic get(input int er, input int ei, input int k, input int stall);
        int t;
        t = 0;
        while (!ov4 && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (!ov4) begin
            fail("get_timeout");
        end else begin
            if (stall > 0) out_ready = 1'b0;
            if (k == 0) bin0_cyc = cyc;
            chk("bin_re", int'($signed(q_re4)), er);
            chk("bin_im", int'($signed(q_im4)), ei);
            chk("out_idx", int'(idx4), k);
            chk("out_last", int'(last4), (k == 3) ? 1 : 0);
            chk("in_ready_during_output", int'(rdy4), 0);
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                chk("stall_valid", int'(ov4), 1);
                chk("stall_re", int'($signed(q_re4)), er);
                chk("stall_im", int'($signed(q_im4)), ei);
                chk("stall_idx", int'(idx4), k);
            end
            out_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic reset_chk(input string tag);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk({tag, "_in_ready"}, int'(rdy4), 1);
        chk({tag, "_out_valid"}, int'(ov4), 0);
        chk({tag, "_out_re"}, int'($signed(q_re4)), 0);
        chk({tag, "_out_im"}, int'($signed(q_im4)), 0);
        chk({tag, "_out_idx"}, int'(idx4), 0);
        chk({tag, "_out_last"}, int'(last4), 0);
    endtask

    task automatic run_vec(input vec_t v);
        for (int n = 0; n < 4; n++) begin
            if (n == 2) begin
                for (int g = 0; g < v.gap; g++) begin
                    @(negedge clk);
                    chk("gap_in_ready", int'(rdy4), 1);
                end
            end
            put(v.re[n], v.re[n], v.re[n], v.im[n], v.im[n], v.im[n], v.inv[n]);
        end
        chk("compute_out_valid", int'(ov4), 0);
        chk("compute_in_ready", int'(rdy4), 0);
        @(negedge clk);
        chk("latency_out_valid", int'(ov4), 1);
        for (int k = 0; k < 4; k++) get(v.er[k], v.ei[k], k, (k == 1) ? v.stall : 0);
    endtask

    initial begin
        vec_t vecs[6];
        int   b0[6];
        vecs[0] = '{'{1, 2, 3, 4}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 0, 0,
                    '{10, -2, -2, -2}, '{0, 2, 0, -2}};
        vecs[1] = '{'{1, 2, 3, 4}, '{0, 0, 0, 0}, '{1, 1, 0, 0}, 0, 0,
                    '{10, -2, -2, -2}, '{0, -2, 0, 2}};
        vecs[2] = '{'{5, 0, 0, 0}, '{3, 0, 0, 0}, '{0, 0, 0, 0}, 0, 0,
                    '{5, 5, 5, 5}, '{3, 3, 3, 3}};
        vecs[3] = '{'{-8, -8, -8, -8}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 0, 0,
                    '{-32, 0, 0, 0}, '{0, 0, 0, 0}};
        vecs[4] = '{'{7, 7, 7, 7}, '{7, 7, 7, 7}, '{0, 0, 0, 0}, 0, 0,
                    '{28, 0, 0, 0}, '{28, 0, 0, 0}};
        vecs[5] = '{'{1, 3, -2, 0}, '{2, -1, 0, 4}, '{0, 0, 0, 0}, 3, 5,
                    '{2, -2, -4, 8}, '{5, -1, -1, 5}};

        reset_chk("reset");
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
            b0[i] = bin0_cyc;
        end
        for (int i = 1; i < 5; i++) chk("frame_period", b0[i] - b0[i-1], 9);

        // Reset with a half-collected frame, then reset while bins are pending.
        put(5, 5, 5, 5, 5, 5, 1);
        put(5, 5, 5, 5, 5, 5, 1);
        reset_chk("rst_collect");
        run_vec(vecs[5]);
        for (int n = 0; n < 4; n++) put(vecs[0].re[n], vecs[0].re[n], vecs[0].re[n], 0, 0, 0, 0);
        get(10, 0, 0, 0);
        get(-2, 2, 1, 0);
        reset_chk("rst_output");
        run_vec(vecs[2]);

        for (int f = 0; f < 1000; f++) begin
            int xr[3][4];
            int xi[3][4];
            int yr[3][4];
            int yi[3][4];
            int ar[4], ai[4], br[4], bi[4];
            int md;
            md = int'($urandom_range(0, 1));
            for (int w = 0; w < 3; w++) begin
                int lim;
                lim = 1 << (3 + 4 * w);
                for (int n = 0; n < 4; n++) begin
                    xr[w][n] = int'($urandom_range(0, 2 * lim - 1)) - lim;
                    xi[w][n] = int'($urandom_range(0, 2 * lim - 1)) - lim;
                    ar[n] = xr[w][n];
                    ai[n] = xi[w][n];
                end
                ref_dft(ar, ai, md, br, bi);
                for (int k = 0; k < 4; k++) begin
                    yr[w][k] = br[k];
                    yi[w][k] = bi[k];
                end
            end
            for (int n = 0; n < 4; n++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                put(xr[0][n], xr[1][n], xr[2][n], xi[0][n], xi[1][n], xi[2][n],
                    (n == 0) ? md : int'($urandom_range(0, 1)));
            end
            for (int k = 0; k < 4; k++) begin
                int t;
                bit got;
                t = 0;
                got = 1'b0;
                while (!got && t < 100) begin
                    out_ready = 1'($urandom_range(0, 1));
                    if (ov4 && out_ready) begin
                        chk("rnd_re4", int'($signed(q_re4)), yr[0][k]);
                        chk("rnd_im4", int'($signed(q_im4)), yi[0][k]);
                        chk("rnd_re8", int'($signed(q_re8)), yr[1][k]);
                        chk("rnd_im8", int'($signed(q_im8)), yi[1][k]);
                        chk("rnd_re12", int'($signed(q_re12)), yr[2][k]);
                        chk("rnd_im12", int'($signed(q_im12)), yi[2][k]);
                        chk("rnd_idx4", int'(idx4), k);
                        chk("rnd_idx8", int'(idx8), k);
                        chk("rnd_idx12", int'(idx12), k);
                        chk("rnd_last4", int'(last4), (k == 3) ? 1 : 0);
                        chk("rnd_last8", int'(last8), (k == 3) ? 1 : 0);
                        chk("rnd_last12", int'(last12), (k == 3) ? 1 : 0);
                        chk("rnd_valid8", int'(ov8), 1);
                        chk("rnd_valid12", int'(ov12), 1);
                        got = 1'b1;
                    end
                    @(negedge clk);
                    t++;
                end
                if (!got) fail("rnd_out_timeout");
            end
            out_ready = 1'b1;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
